// File: rtl/div32by16_seq.sv
// Sequential signed divider, 2W-bit dividend by W-bit divisor, radix-2 restoring core.
// Quotient truncates toward zero; remainder follows the dividend sign; flags for /0 and overflow.
module div32by16_seq #(
    parameter int unsigned W = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [2*W-1:0] i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [W-1:0]   o_q,
    output logic [W-1:0]   o_r,
    output logic           o_dbz,
    output logic           o_ovf
);

    localparam int unsigned CW = $clog2(2 * W);
    localparam logic [2*W-1:0] PosLim = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [2*W-1:0] NegLim = {{W{1'b0}}, 1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0] SatPos = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] SatNeg = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] dvd_q, dvd_d;   // dividend magnitude, becomes quotient magnitude
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   bmag_q, bmag_d;
    logic           sign_q_q, sign_q_d;
    logic           sign_r_q, sign_r_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   r_q, r_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;
    logic           valid_q, valid_d;

    logic [W:0]     rem_sh;
    logic [W:0]     rem_sub;
    logic           rem_ge;
    logic           ovf_now;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        bmag_d   = bmag_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        q_d      = q_q;
        r_d      = r_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        rem_sh   = {rem_q[W-1:0], dvd_q[2*W-1]};
        rem_sub  = rem_sh - {1'b0, bmag_q};
        rem_ge   = (rem_sh >= {1'b0, bmag_q});
        ovf_now  = sign_q_q ? (dvd_q > NegLim) : (dvd_q > PosLim);

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    dvd_d    = i_a[2*W-1] ? -i_a : i_a;
                    bmag_d   = i_b[W-1] ? -i_b : i_b;
                    sign_q_d = i_a[2*W-1] ^ i_b[W-1];
                    sign_r_d = i_a[2*W-1];
                    rem_d    = '0;
                    cnt_d    = CW'(2 * W - 1);
                    ovf_d    = 1'b0;
                    if (i_b == '0) begin
                        state_d = StDone;
                        dbz_d   = 1'b1;
                        q_d     = i_a[2*W-1] ? SatNeg : SatPos;
                        r_d     = i_a[W-1:0];
                    end else begin
                        state_d = StCalc;
                        dbz_d   = 1'b0;
                        q_d     = '0;
                        r_d     = '0;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_ge ? rem_sub : rem_sh;
                dvd_d = {dvd_q[2*W-2:0], rem_ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
                if (ovf_now) begin
                    ovf_d = 1'b1;
                    q_d   = sign_q_q ? SatNeg : SatPos;
                    r_d   = '0;
                end else begin
                    q_d = sign_q_q ? -dvd_q[W-1:0] : dvd_q[W-1:0];
                    r_d = sign_r_q ? -rem_q[W-1:0] : rem_q[W-1:0];
                end
            end
            StDone: begin
                // Result is presented one cycle after DONE entry and held until consumed.
                valid_d = !(valid_q && i_ready);
                if (valid_q && i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            bmag_q   <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            bmag_q   <= bmag_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            q_q      <= q_d;
            r_q      <= r_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready = (state_q == StIdle) && !i_rst;
    assign o_valid = valid_q;
    assign o_q     = q_q;
    assign o_r     = r_q;
    assign o_dbz   = dbz_q;
    assign o_ovf   = ovf_q;

endmodule

// File: doc/div32by16_seq.md
# div32by16_seq

Sequential signed divider: 32-bit dividend by 16-bit divisor, giving a 16-bit quotient and a 16-bit remainder. It is the inverse of the 16x16->32 multiplier path and is used to recover operands and normalise products in the approximate-multiplier evaluation datapath. It is exact, not approximate, so it also serves as a golden reference when measuring multiplier error. It uses a radix-2 restoring core, one bit per cycle, with valid/ready handshakes on both input and output.

## Interface
- W, 16, divisor/quotient/remainder width; dividend width is 2W
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request
- i_a  in  2W  signed dividend
- i_b  in  W  signed divisor
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_q  out  W  signed quotient
- o_r  out  W  signed remainder
- o_dbz  out  1  divide-by-zero flag
- o_ovf  out  1  quotient-overflow flag

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready, capture |i_a| (2W-bit unsigned; -2^31 -> 0x8000_0000), |i_b|, sign_q = a[31]^b[15], and sign_r = a[31].
  - If i_b==0 go to DONE; otherwise go to CALC with the iteration counter at 2W-1.
- CALC, one restoring step per cycle:
  - rem = {rem[W:0], dividend msb}; shift the dividend left.
  - If rem >= |b|, subtract and shift in quotient bit 1; else shift in 0.
  - The partial remainder is W+1 bits.
  - After 2W steps (counter hits 0) go to FIX.
- FIX:
  - Apply the signs: q = sign_q ? -qmag : qmag; r = sign_r ? -rmag : rmag.
  - Overflow when qmag > 2^(W-1)-1 with sign_q=0, or qmag > 2^(W-1) with sign_q=1.
  - Go to DONE.
- DONE:
  - o_valid=1; outputs held stable.
  - On i_valid... no: on o_valid & i_ready, return to IDLE.
- Rounding: quotient truncates toward zero; remainder takes the sign of the dividend (or is 0); a = q*b + r whenever neither flag is set.
- Divide by zero: o_dbz=1, o_ovf=0, o_q = a>=0 ? 2^(W-1)-1 : -2^(W-1), o_r = i_a[W-1:0].
- Overflow: o_ovf=1, o_dbz=0, o_q saturates (positive 2^(W-1)-1, negative -2^(W-1)), o_r=0.
- The flags are valid only while o_valid=1 and are cleared on every new accept.
- o_ready=0 in CALC, FIX and DONE. i_valid outside IDLE is ignored; the request is not queued.

## Timing
- Reset:
  - State goes to IDLE at the next edge with i_rst=1.
  - o_valid=0, o_q=0, o_r=0, o_dbz=0, o_ovf=0.
  - o_ready is forced 0 while i_rst=1 and is 1 from the first cycle after release.
- Reset mid-operation: the computation is abandoned, no result is produced, and the block is idle next cycle.
- Latency for a nonzero divisor: accept at edge T; o_valid=1 from edge T+2W+2 (34 cycles for W=16).
- Latency for divide by zero: o_valid=1 from edge T+1.
- Back-to-back throughput: o_ready returns 1 in the cycle after the output handshake, so there is no accept in the same cycle as a result is consumed.
- Backpressure: o_valid, o_q, o_r and the flags stay constant for any number of cycles with i_ready=0.
- i_ready with o_valid=0 has no effect.

## Test plan
- Positive operands: 1000/7 -> q=142, r=6, flags 0, o_valid exactly 34 cycles after accept.
- Signed combinations, each with no flags:
  - -1000/7 -> q=-142, r=-6.
  - 1000/-7 -> q=-142, r=6.
  - -1000/-7 -> q=142, r=-6.
  - 1073741824 / -32768 -> q=-32768, r=0.
- Divide by zero: 1000/0 -> o_dbz=1, q=32767, r=1000, o_valid 1 cycle after accept. -5/0 -> q=-32768, r=0xFFFB.
- Overflow:
  - 0x7FFFFFFF/1 -> o_ovf=1, q=32767, r=0.
  - -2^31/-1 -> o_ovf=1, q=32767.
  - -2^31/1 -> o_ovf=1, q=-32768.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid -> outputs stable, o_ready=0, and an i_valid pulse in that window is dropped. Release -> o_ready=1 in the next cycle.
- Reset mid-CALC: assert i_rst at iteration 10 -> no o_valid, outputs 0, o_ready=1 after release. A following 1000/7 gives the correct result.
